// File: rtl/vga_column_plotter.sv
// Column pixel engine: buffered column commands in, one frame-buffer write per clock out.
// Optional per-command wall darkening via VGA_COLUMN_PLOTTER_DEPTH_SHADE_EN.
module vga_column_plotter #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOUR_BITS = 18,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [X_BITS-1:0]      req_x,
  input  logic [Y_BITS-1:0]      req_top,
  input  logic [Y_BITS-1:0]      req_bottom,
  input  logic [COLOUR_BITS-1:0] req_colour,
`ifdef VGA_COLUMN_PLOTTER_DEPTH_SHADE_EN
  input  logic [1:0]             req_shade,
`endif
  input  logic [COLOUR_BITS-1:0] ceil_colour,
  input  logic [COLOUR_BITS-1:0] floor_colour,
  output logic [X_BITS-1:0]      vga_x,
  output logic [Y_BITS-1:0]      vga_y,
  output logic [COLOUR_BITS-1:0] vga_colour,
  output logic                   vga_write,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CH    = COLOUR_BITS / 3;
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [Y_BITS-1:0] LAST_Y   = Y_BITS'(SCREEN_H - 1);
  localparam logic [X_BITS-1:0] LAST_X   = X_BITS'(SCREEN_W - 1);

  typedef struct packed {
    logic [X_BITS-1:0]      x;
    logic [Y_BITS-1:0]      top;
    logic [Y_BITS-1:0]      bot;
    logic [COLOUR_BITS-1:0] wall;
`ifdef VGA_COLUMN_PLOTTER_DEPTH_SHADE_EN
    logic [1:0]             shade;
`endif
  } cmd_t;

  typedef struct packed {
    logic [X_BITS-1:0]      x;
    logic [Y_BITS-1:0]      top;
    logic [Y_BITS-1:0]      bot;
    logic [COLOUR_BITS-1:0] wall;
    logic [COLOUR_BITS-1:0] ceil;
    logic [COLOUR_BITS-1:0] flr;
  } col_t;

  typedef enum logic {IDLE, DRAW} state_t;

`ifdef VGA_COLUMN_PLOTTER_DEPTH_SHADE_EN
  function automatic logic [COLOUR_BITS-1:0] shade_wall(input logic [COLOUR_BITS-1:0] c,
                                                        input logic [1:0] s);
    logic [COLOUR_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*CH +: CH] = c[i*CH +: CH] >> s;
    return r;
  endfunction
`endif

  // Rows above top are ceiling, top..bot wall, rest floor; top > bot yields no wall.
  function automatic logic [COLOUR_BITS-1:0] pick(input logic [Y_BITS-1:0] y, input col_t c);
    if (y < c.top)       return c.ceil;
    else if (y <= c.bot) return c.wall;
    else                 return c.flr;
  endfunction

  // ---------------- command FIFO ----------------
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             cmd_in, head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_n;
  logic             push, pop, empty, in_range;

  assign req_ready = (count != FULL_CNT);
  assign empty     = (count == '0);
  assign in_range  = ({1'b0, req_x} < (X_BITS+1)'(SCREEN_W));
  assign push      = req_valid && req_ready && in_range;
  assign head      = mem[rd_ptr];

  always_comb begin
    cmd_in      = '0;
    cmd_in.x    = req_x;
    cmd_in.top  = req_top;
    cmd_in.bot  = req_bottom;
    cmd_in.wall = req_colour;
`ifdef VGA_COLUMN_PLOTTER_DEPTH_SHADE_EN
    cmd_in.shade = req_shade;
`endif
  end

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
    end
  end

  // ---------------- column FSM ----------------
  state_t           state, state_n;
  col_t             col, col_n, col_load;
  logic [Y_BITS-1:0] y_cnt, y_n;

  always_comb begin
    col_load      = '0;
    col_load.x    = head.x;
    col_load.top  = head.top;
    col_load.bot  = head.bot;
`ifdef VGA_COLUMN_PLOTTER_DEPTH_SHADE_EN
    col_load.wall = shade_wall(head.wall, head.shade);
`else
    col_load.wall = head.wall;
`endif
    col_load.ceil = ceil_colour;
    col_load.flr  = floor_colour;
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    y_n     = y_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        col_n   = col_load;
        y_n     = '0;
        state_n = DRAW;
      end
      DRAW: begin
        if (y_cnt == LAST_Y) begin
          if (!empty) begin
            pop   = 1'b1;
            col_n = col_load;
            y_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          y_n = y_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the pixel appears the cycle after the pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      y_cnt      <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      y_cnt     <= y_n;
      vga_write <= (state_n == DRAW);
      if (state_n == DRAW) begin
        vga_x      <= col_n.x;
        vga_y      <= y_n;
        vga_colour <= pick(y_n, col_n);
      end
      frame_done <= (state == DRAW) && (y_cnt == LAST_Y) && (col.x == LAST_X);
      busy       <= (count_n != '0) || (state_n == DRAW);
    end
  end

endmodule
